// File: rtl/nfc_pkg.sv
// Shared encodings for the NFC host sequencer: controller commands, response
// status codes, sequencer states and page geometry.
package nfc_pkg;

    localparam int PAGE_BYTES = 2048;
    localparam int BYTE_AW    = $clog2(PAGE_BYTES);

    localparam logic [2:0] CMD_WRITE  = 3'b001;
    localparam logic [2:0] CMD_READ   = 3'b010;
    localparam logic [2:0] CMD_RESET  = 3'b011;
    localparam logic [2:0] CMD_ERASE  = 3'b100;
    localparam logic [2:0] CMD_READID = 3'b101;
    localparam logic [2:0] CMD_NOP    = 3'b111;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_FLASH_ERR = 2'b01,
        ST_TIMEOUT   = 2'b10,
        ST_ILLEGAL   = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_ARM,
        S_WAIT_DONE,
        S_DR_ADDR,
        S_DR_DATA,
        S_RESP
    } state_e;

    function automatic logic cmd_legal(input logic [2:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_ERASE) ||
               (cmd == CMD_RESET) || (cmd == CMD_READID);
    endfunction

    // Only the error flag belonging to the finished operation matters;
    // reset and read ID never report a flash error.
    function automatic status_e done_status(input logic [2:0] cmd,
                                            input logic       perr,
                                            input logic       eerr,
                                            input logic       rerr);
        status_e st;
        st = ST_OK;
        case (cmd)
            CMD_WRITE: if (perr) st = ST_FLASH_ERR;
            CMD_ERASE: if (eerr) st = ST_FLASH_ERR;
            CMD_READ:  if (rerr) st = ST_FLASH_ERR;
            default:   st = ST_OK;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/nfc_watchdog.sv
// Cycle counter that flags when an enabled wait has lasted TIMEOUT_CYC cycles.
// The count includes the first enabled cycle, so expired_o rises in cycle TIMEOUT_CYC-1.
module nfc_watchdog #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [23:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == TIMEOUT_CYC - 24'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nfc_host_seq.sv
// Host-side sequencer for nfcm_top: accepts page write/read, erase, reset and
// read-ID requests, streams page data through the page buffer and reports status.
module nfc_host_seq
    import nfc_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [2:0]  host_cmd,
    input  logic [15:0] host_rwa,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        resp_valid,
    output logic [1:0]  resp_status,
    output logic        BF_sel,
    output logic [10:0] BF_ad,
    output logic [7:0]  BF_din,
    output logic        BF_we,
    input  logic [7:0]  BF_dou,
    output logic [15:0] RWA,
    output logic [2:0]  nfc_cmd,
    output logic        nfc_strt,
    input  logic        nfc_done,
    input  logic        PErr,
    input  logic        EErr,
    input  logic        RErr
);

    localparam logic [BYTE_AW-1:0] LAST_BYTE = BYTE_AW'(PAGE_BYTES - 1);

    state_e               state_q, state_d;
    logic [BYTE_AW-1:0]   cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    status_e              stat_q, stat_d;
    logic                 host_ready_q;
    logic                 bf_we_q, bf_we_d;
    logic [BYTE_AW-1:0]   bf_ad_q, bf_ad_d;
    logic [7:0]           bf_din_q, bf_din_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [15:0]          rwa_q, rwa_d;
    logic [2:0]           nfc_cmd_q, nfc_cmd_d;
    status_e              resp_status_q, resp_status_d;

    logic host_acc, wr_acc, rd_acc, last_byte;
    logic wd_clr, wd_en, wd_expired;

    assign host_acc  = host_valid && host_ready_q;
    assign wr_acc    = wr_valid && (state_q == S_FILL);
    assign rd_acc    = rd_valid_q && rd_ready;
    assign last_byte = (cnt_q == LAST_BYTE);

    // ARM is counted too, so the timeout is measured from the start of ARM.
    assign wd_en  = (state_q == S_ARM) || (state_q == S_WAIT_DONE);
    assign wd_clr = !wd_en;

    nfc_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i     (CLK),
        .rst_n_i   (rst_n),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            stat_q        <= ST_OK;
            host_ready_q  <= 1'b0;
            bf_we_q       <= 1'b0;
            bf_ad_q       <= '0;
            bf_din_q      <= '0;
            rd_valid_q    <= 1'b0;
            rwa_q         <= '0;
            nfc_cmd_q     <= CMD_NOP;
            resp_status_q <= ST_OK;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stat_q        <= stat_d;
            host_ready_q  <= (state_d == S_IDLE);
            bf_we_q       <= bf_we_d;
            bf_ad_q       <= bf_ad_d;
            bf_din_q      <= bf_din_d;
            rd_valid_q    <= rd_valid_d;
            rwa_q         <= rwa_d;
            nfc_cmd_q     <= nfc_cmd_d;
            resp_status_q <= resp_status_d;
        end
    end

    always_ff @(posedge CLK) begin
        op_q      <= op_d;
        rd_data_q <= rd_data_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE: begin
                if (host_acc) begin
                    op_d  = host_cmd;
                    cnt_d = '0;
                    if (host_cmd == CMD_WRITE) begin
                        state_d = S_FILL;
                    end else if (cmd_legal(host_cmd)) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_RESP;
                        stat_d  = ST_ILLEGAL;
                    end
                end
            end
            S_FILL: begin
                if (wr_acc) begin
                    cnt_d = cnt_q + BYTE_AW'(1);
                    if (last_byte) state_d = S_START;
                end
            end
            S_START: state_d = S_ARM;
            S_ARM:   state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // A done arriving in the expiry cycle takes precedence.
                if (nfc_done) begin
                    stat_d  = done_status(op_q, PErr, EErr, RErr);
                    state_d = (op_q == CMD_READ) ? S_DR_ADDR : S_RESP;
                end else if (wd_expired) begin
                    stat_d  = ST_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            S_DR_ADDR: state_d = S_DR_DATA;
            S_DR_DATA: begin
                if (rd_acc) begin
                    cnt_d   = cnt_q + BYTE_AW'(1);
                    state_d = last_byte ? S_RESP : S_DR_ADDR;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready   = (state_q == S_FILL);
        nfc_strt   = (state_q == S_START);
        resp_valid = (state_q == S_RESP);
        // The last FILL write lands in START, so keep the buffer selected for it.
        BF_sel     = (state_q inside {S_FILL, S_DR_ADDR, S_DR_DATA}) || bf_we_q;

        bf_we_d  = wr_acc;
        bf_ad_d  = bf_ad_q;
        bf_din_d = bf_din_q;
        if (wr_acc) begin
            bf_ad_d  = cnt_q;
            bf_din_d = wr_data;
        end
        if (state_d == S_DR_ADDR) bf_ad_d = cnt_d;

        // First DR_DATA cycle captures the buffer output; rd_valid follows.
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if ((state_q == S_DR_DATA) && !rd_valid_q) begin
            rd_data_d  = BF_dou;
            rd_valid_d = 1'b1;
        end else if (rd_acc) begin
            rd_valid_d = 1'b0;
        end

        rwa_d = host_acc ? host_rwa : rwa_q;

        nfc_cmd_d = nfc_cmd_q;
        if ((state_d == S_IDLE) || (state_d == S_RESP)) begin
            nfc_cmd_d = CMD_NOP;
        end else if (host_acc) begin
            nfc_cmd_d = host_cmd;
        end

        resp_status_d = ((state_d == S_RESP) && (state_q != S_RESP)) ? stat_d : resp_status_q;
    end

    assign host_ready  = host_ready_q;
    assign BF_we       = bf_we_q;
    assign BF_ad       = bf_ad_q;
    assign BF_din      = bf_din_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign RWA         = rwa_q;
    assign nfc_cmd     = nfc_cmd_q;
    assign resp_status = resp_status_q;

endmodule

// File: tb/tb_nfc_host_seq.sv
// Directed bench for nfc_host_seq with a page-buffer RAM and a simple controller model.
module tb_nfc_host_seq;
    import nfc_pkg::*;

    localparam logic [23:0] TMO = 24'd100;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  host_cmd = 3'b000;
    logic [15:0] host_rwa = 16'h0000;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic        BF_sel;
    logic [10:0] BF_ad;
    logic [7:0]  BF_din;
    logic        BF_we;
    logic [7:0]  BF_dou;
    logic [15:0] RWA;
    logic [2:0]  nfc_cmd;
    logic        nfc_strt;
    logic        nfc_done;
    logic        PErr = 1'b0;
    logic        EErr = 1'b0;
    logic        RErr = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    nfc_host_seq #(.TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .host_cmd(host_cmd), .host_rwa(host_rwa), .host_valid(host_valid), .host_ready(host_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .resp_valid(resp_valid), .resp_status(resp_status),
        .BF_sel(BF_sel), .BF_ad(BF_ad), .BF_din(BF_din), .BF_we(BF_we), .BF_dou(BF_dou),
        .RWA(RWA), .nfc_cmd(nfc_cmd), .nfc_strt(nfc_strt), .nfc_done(nfc_done),
        .PErr(PErr), .EErr(EErr), .RErr(RErr)
    );

    always #5 CLK = ~CLK;

    int cyc;
    always @(posedge CLK) cyc <= cyc + 1;

    // Page-buffer RAM: read data appears one cycle after the address.
    logic [7:0] mem [2048];
    always @(posedge CLK) begin
        if (BF_sel && BF_we) mem[BF_ad] <= BF_din;
        BF_dou <= mem[BF_ad];
    end

    // Controller model: done pulses done_dly+1 cycles after the start cycle.
    int done_dly = 8;
    logic hold_done = 1'b0;
    int ctl_dly;
    int strt_cnt;
    int strt_cyc;
    logic [2:0]  strt_cmd;
    logic [15:0] strt_rwa;
    always @(posedge CLK) begin
        nfc_done <= 1'b0;
        if (nfc_strt) begin
            strt_cnt <= strt_cnt + 1;
            strt_cyc <= cyc;
            strt_cmd <= nfc_cmd;
            strt_rwa <= RWA;
            ctl_dly  <= done_dly;
        end else if (ctl_dly != 0) begin
            ctl_dly <= ctl_dly - 1;
            if (ctl_dly == 1 && !hold_done) nfc_done <= 1'b1;
        end
    end

    logic [7:0] pat [2048];

    // Page-buffer write monitor: address sequence and data against the pattern.
    int we_cnt;
    int we_idx;
    int we_bad;
    always @(posedge CLK) begin
        if (!rst_n) begin
            we_idx <= 0;
        end else if (BF_we) begin
            we_cnt <= we_cnt + 1;
            if (BF_ad != 11'(we_idx) || BF_din != pat[we_idx] || !BF_sel) we_bad <= we_bad + 1;
            we_idx <= (we_idx == 2047) ? 0 : we_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [15:0] rwa);
        int n;
        n = 0;
        host_cmd = cmd;
        host_rwa = rwa;
        host_valid = 1'b1;
        while (!host_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("host_ready", host_ready, 1);
        @(negedge CLK);
        host_valid = 1'b0;
    endtask

    task automatic wait_resp(input int max_cyc, output logic [1:0] st, output int at_cyc, output int waited);
        waited = 0;
        while (!resp_valid && waited < max_cyc) begin
            @(negedge CLK);
            waited++;
        end
        chk("resp_seen", resp_valid, 1);
        chk("resp_nfc_cmd", nfc_cmd, CMD_NOP);
        chk("resp_bf_sel", BF_sel, 0);
        st = resp_status;
        at_cyc = cyc;
        @(negedge CLK);
        chk("resp_pulse_end", resp_valid, 0);
        chk("resp_status_hold", resp_status, st);
    endtask

    task automatic send_bytes(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            if (i % 7 == 3) begin
                wr_valid = 1'b0;
                @(negedge CLK);
            end
            wr_data = pat[i];
            wr_valid = 1'b1;
            w = 0;
            while (!wr_ready && w < 20) begin
                @(negedge CLK);
                w++;
            end
            if (!wr_ready) chk("wr_ready", wr_ready, 1);
            @(negedge CLK);
        end
        wr_valid = 1'b0;
    endtask

    task automatic do_write();
        logic [1:0] st;
        int at, waited, s0, w0, b0;
        for (int i = 0; i < 2048; i++) pat[i] = 8'($urandom_range(0, 255));
        s0 = strt_cnt; w0 = we_cnt; b0 = we_bad;
        issue(CMD_WRITE, 16'h1234);
        chk("fill_nfc_cmd", nfc_cmd, CMD_WRITE);
        chk("fill_bf_sel", BF_sel, 1);
        send_bytes(2048);
        wait_resp(200, st, at, waited);
        chk("wr_we_pulses", we_cnt - w0, 2048);
        chk("wr_we_addr_data", we_bad - b0, 0);
        chk("wr_strt_cnt", strt_cnt - s0, 1);
        chk("wr_strt_cmd", strt_cmd, CMD_WRITE);
        chk("wr_strt_rwa", strt_rwa, 16'h1234);
        chk("wr_status", st, ST_OK);
    endtask

    task automatic do_read(input logic [1:0] exp_st);
        logic [1:0] st;
        int at, waited, got, bad, n;
        logic tog;
        got = 0; bad = 0; n = 0; tog = 1'b0;
        issue(CMD_READ, 16'h1234);
        while (got < 2048 && n < 30000) begin
            rd_ready = tog;
            if (rd_valid && rd_ready) begin
                if (rd_data != pat[got]) bad++;
                got++;
            end
            tog = ~tog;
            @(negedge CLK);
            n++;
        end
        rd_ready = 1'b0;
        chk("rd_count", got, 2048);
        chk("rd_data_bad", bad, 0);
        wait_resp(50, st, at, waited);
        chk("rd_strt_cmd", strt_cmd, CMD_READ);
        chk("rd_status", st, exp_st);
    endtask

    task automatic simple_op(input logic [2:0] cmd, input logic [1:0] exp_st, input int exp_strt,
                             input string tag, output int waited, output int at);
        logic [1:0] st;
        int s0;
        s0 = strt_cnt;
        issue(cmd, 16'h1234);
        wait_resp(300, st, at, waited);
        chk({tag, "_status"}, st, exp_st);
        chk({tag, "_strt_cnt"}, strt_cnt - s0, exp_strt);
        if (exp_strt != 0) chk({tag, "_strt_cmd"}, strt_cmd, cmd);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int waited, at;

        repeat (3) @(negedge CLK);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_bf_sel", BF_sel, 0);
        chk("rst_bf_we", BF_we, 0);
        chk("rst_nfc_strt", nfc_strt, 0);
        chk("rst_bf_ad", BF_ad, 0);
        chk("rst_bf_din", BF_din, 0);
        chk("rst_rwa", RWA, 0);
        chk("rst_nfc_cmd", nfc_cmd, CMD_NOP);
        chk("rst_resp_status", resp_status, ST_OK);
        rst_n = 1'b1;
        @(negedge CLK);
        chk("rel_host_ready", host_ready, 1);

        do_write();
        do_read(ST_OK);

        EErr = 1'b1;
        simple_op(CMD_ERASE, ST_FLASH_ERR, 1, "erase_err", waited, at);
        PErr = 1'b1; RErr = 1'b1;
        simple_op(CMD_READID, ST_OK, 1, "readid", waited, at);
        simple_op(CMD_RESET, ST_OK, 1, "reset_cmd", waited, at);
        PErr = 1'b0; EErr = 1'b0; RErr = 1'b0;

        simple_op(3'b110, ST_ILLEGAL, 0, "illegal", waited, at);
        chk("illegal_latency", (waited <= 2), 1);

        // Done in the very cycle the watchdog expires: done wins.
        done_dly = 99;
        simple_op(CMD_ERASE, ST_OK, 1, "race", waited, at);
        chk("race_latency", at - strt_cyc, 101);
        done_dly = 8;

        hold_done = 1'b1;
        simple_op(CMD_ERASE, ST_TIMEOUT, 1, "timeout", waited, at);
        chk("timeout_latency", at - strt_cyc, 101);
        hold_done = 1'b0;

        for (int i = 0; i < 2048; i++) pat[i] = 8'($urandom_range(0, 255));
        issue(CMD_WRITE, 16'h0042);
        send_bytes(1000);
        rst_n = 1'b0;
        @(negedge CLK);
        chk("mid_rst_bf_sel", BF_sel, 0);
        chk("mid_rst_nfc_cmd", nfc_cmd, CMD_NOP);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_host_ready", host_ready, 0);
        chk("mid_rst_bf_we", BF_we, 0);
        chk("mid_rst_bf_ad", BF_ad, 0);
        chk("mid_rst_rwa", RWA, 0);
        chk("mid_rst_resp_status", resp_status, ST_OK);
        rst_n = 1'b1;
        @(negedge CLK);
        chk("mid_rel_host_ready", host_ready, 1);

        do_write();
        RErr = 1'b1;
        do_read(ST_FLASH_ERR);
        RErr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
